alu_exec_unit: RTL and testbench

- Execute-stage ALU for the reduced RISC-V pipeline; directly consumes the 3-bit ALUControl code from the ALU decoder together with the ID/EX operands.
- Single-cycle ops (add, sub, and, or, slt) complete with registered latency 1.
- SLL uses an area-saving iterative shifter, one bit per cycle; the unit stalls upstream while it runs.
- Drives the EX/MEM side: result, zero flag (branch compare) and destination tag.

---
 rtl/alu_exec_unit.sv | 127 ++++++++++++
 tb/tb_alu_exec_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/and/or/slt plus an iterative
// one-bit-per-cycle sll that stalls upstream while it runs.
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [4:0]       rd_out
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLL = 3'b100,
        OP_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     acc_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [4:0]           rd_pend_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;
    logic [4:0]           rd_out_q;
    logic                 out_valid_q;

    logic [WIDTH-1:0]     single_res_d;
    logic [WIDTH-1:0]     acc_shl_d;
    logic [SHAMT_W-1:0]   shamt;
    logic                 slt_lt;
    logic                 accept;
    logic                 start_shift;

    assign in_ready    = (state_q == S_IDLE);
    assign accept      = in_valid && in_ready && !flush;
    assign shamt       = src_b[SHAMT_W-1:0];
    assign start_shift = (alu_control == OP_SLL) && (shamt != '0);
    assign acc_shl_d   = {acc_q[WIDTH-2:0], 1'b0};
    assign slt_lt      = $signed(src_a) < $signed(src_b);

    // Single-cycle datapath; sll here only covers shamt == 0 (pass-through).
    always_comb begin
        single_res_d = src_a + src_b;
        case (alu_control)
            OP_SUB:  single_res_d = src_a - src_b;
            OP_AND:  single_res_d = src_a & src_b;
            OP_OR:   single_res_d = src_a | src_b;
            OP_SLL:  single_res_d = src_a;
            OP_SLT:  single_res_d = WIDTH'(slt_lt);
            default: single_res_d = src_a + src_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            rd_pend_q   <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rd_out_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (start_shift) begin
                            acc_q     <= src_a;
                            cnt_q     <= shamt;
                            rd_pend_q <= rd_in;
                            state_q   <= S_SHIFT;
                        end else begin
                            result_q    <= single_res_d;
                            zero_q      <= (single_res_d == '0);
                            rd_out_q    <= rd_in;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    // Flush abandons the shift; result keeps its previous value.
                    if (flush) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == SHAMT_W'(1)) begin
                        result_q    <= acc_shl_d;
                        zero_q      <= (acc_shl_d == '0);
                        rd_out_q    <= rd_pend_q;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        acc_q <= acc_shl_d;
                        cnt_q <= cnt_q - SHAMT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, multi-cycle corner sequences
// and random operations checked against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    alu_control;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [4:0]    rd_in;
    logic          flush;
    logic          out_valid;
    logic [W-1:0]  result;
    logic          zero;
    logic [4:0]    rd_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .rd_in(rd_in),
        .flush(flush), .out_valid(out_valid), .result(result), .zero(zero),
        .rd_out(rd_out)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   rd;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation code.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        case (op)
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a << b[SW-1:0];
            3'd5:    return (sa < sb) ? W'(1) : W'(0);
            default: return a + b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and follow it to completion, checking latency and stall length.
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] rd, input logic [W-1:0] exp);
        int n;
        int cyc;
        int low;
        n = (op == 3'b100) ? int'(b[SW-1:0]) : 0;
        check_b({name, " ready_before"}, in_ready, 1'b1);
        in_valid = 1'b1; alu_control = op; src_a = a; src_b = b; rd_in = rd;
        tick();
        in_valid = 1'b0; src_a = $urandom; src_b = $urandom; rd_in = 5'($urandom);
        cyc = 0;
        low = 0;
        while (!out_valid && cyc < 40) begin
            if (!in_ready) low++;
            tick();
            cyc++;
        end
        check({name, " latency"}, W'(cyc + 1), W'(n + 1));
        check({name, " stall_cycles"}, W'(low), W'(n));
        check({name, " result"}, result, exp);
        check_b({name, " zero"}, zero, exp == '0);
        check({name, " rd_out"}, W'(rd_out), W'(rd));
        check_b({name, " ready_done"}, in_ready, 1'b1);
        tick();
        check_b({name, " pulse_end"}, out_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rop;
        logic [4:0]   rrd;
        int           pulses;

        vecs[0]  = '{3'b000, 32'd5,        32'd7,        5'd3,  32'd12};
        vecs[1]  = '{3'b001, 32'h1234,     32'h1234,     5'd4,  32'h0};
        vecs[2]  = '{3'b001, 32'h0,        32'h1,        5'd5,  32'hFFFF_FFFF};
        vecs[3]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd6,  32'hF000_F000};
        vecs[4]  = '{3'b011, 32'h0F0F0000, 32'h000000F0, 5'd7,  32'h0F0F_00F0};
        vecs[5]  = '{3'b101, 32'hFFFF_FFFF, 32'h1,       5'd8,  32'h1};
        vecs[6]  = '{3'b101, 32'h1,        32'hFFFF_FFFF, 5'd9, 32'h0};
        vecs[7]  = '{3'b101, 32'h5,        32'h5,        5'd10, 32'h0};
        vecs[8]  = '{3'b100, 32'h1,        32'h23,       5'd11, 32'h8};
        vecs[9]  = '{3'b100, 32'hDEADBEEF, 32'h20,       5'd12, 32'hDEAD_BEEF};
        vecs[10] = '{3'b100, 32'h3,        32'h1F,       5'd13, 32'h8000_0000};
        vecs[11] = '{3'b110, 32'h2,        32'h3,        5'd14, 32'h5};
        vecs[12] = '{3'b111, 32'hFFFF_FFFF, 32'h1,       5'd31, 32'h0};

        rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
        alu_control = '0; src_a = '0; src_b = '0; rd_in = '0;
        tick();
        tick();
        check_b("reset out_valid", out_valid, 1'b0);
        check("reset result", result, '0);
        check_b("reset zero", zero, 1'b0);
        check("reset rd_out", W'(rd_out), '0);
        rst = 1'b1;
        tick();
        check_b("reset in_ready", in_ready, 1'b1);

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

        // Back-to-back single-cycle ops produce consecutive pulses in order.
        in_valid = 1'b1; alu_control = 3'b000; src_a = 32'd10; src_b = 32'd20; rd_in = 5'd1;
        tick();
        check_b("b2b pulse1", out_valid, 1'b1);
        check("b2b result1", result, 32'd30);
        check("b2b rd1", W'(rd_out), 32'd1);
        alu_control = 3'b001; src_a = 32'd50; src_b = 32'd8; rd_in = 5'd2;
        tick();
        check_b("b2b pulse2", out_valid, 1'b1);
        check("b2b result2", result, 32'd42);
        check("b2b rd2", W'(rd_out), 32'd2);
        alu_control = 3'b011; src_a = 32'h100; src_b = 32'h1; rd_in = 5'd3;
        tick();
        in_valid = 1'b0;
        check_b("b2b pulse3", out_valid, 1'b1);
        check("b2b result3", result, 32'h101);
        check("b2b rd3", W'(rd_out), 32'd3);
        // Flush during a result cycle does not cancel that result.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_b("b2b pulse_end", out_valid, 1'b0);
        check("b2b hold", result, 32'h101);

        // Flush mid-shift: no pulse, unit returns to idle, result untouched.
        prev = 32'h101;
        in_valid = 1'b1; alu_control = 3'b100; src_a = 32'h1; src_b = 32'd10; rd_in = 5'd20;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check_b("flush in_shift", in_ready, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_b("flush no_pulse", out_valid, 1'b0);
        check_b("flush ready", in_ready, 1'b1);
        check("flush result_held", result, prev);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) pulses++;
            tick();
        end
        check("flush late_pulses", W'(pulses), '0);
        run_op("after_flush add", 3'b000, 32'd100, 32'd23, 5'd21, 32'd123);

        // Same-cycle flush and in_valid: operation dropped.
        in_valid = 1'b1; flush = 1'b1; alu_control = 3'b000; src_a = 32'd1; src_b = 32'd1; rd_in = 5'd9;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check_b("flush_same no_pulse", out_valid, 1'b0);
        check("flush_same result_held", result, 32'd123);
        tick();
        check_b("flush_same no_late", out_valid, 1'b0);

        // Reset during a shift clears outputs and abandons the op.
        in_valid = 1'b1; alu_control = 3'b100; src_a = 32'h5; src_b = 32'd20; rd_in = 5'd17;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_b("rst_shift out_valid", out_valid, 1'b0);
        check("rst_shift result", result, '0);
        check_b("rst_shift zero", zero, 1'b0);
        check("rst_shift rd_out", W'(rd_out), '0);
        rst = 1'b1;
        tick();
        check_b("rst_shift ready", in_ready, 1'b1);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) pulses++;
            tick();
        end
        check("rst_shift late_pulses", W'(pulses), '0);

        // Random operations against the reference model.
        prev = result;
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            rrd = 5'($urandom);
            if ($urandom_range(0, 3) == 0) ra = rb;
            if ($urandom_range(0, 9) == 0) begin
                in_valid = 1'b1; flush = 1'b1; alu_control = rop; src_a = ra; src_b = rb; rd_in = rrd;
                tick();
                in_valid = 1'b0; flush = 1'b0;
                check_b($sformatf("rnd%0d flushed", i), out_valid, 1'b0);
                check($sformatf("rnd%0d held", i), result, prev);
            end else begin
                run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, rrd, model(rop, ra, rb));
                prev = model(rop, ra, rb);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
